// File: rtl/fifo_rd_stream.sv
// Read-side stream consumer for the async FIFO: credit-based pop generation into a
// 3-entry register buffer, presented as valid/ready. Optional read-level logic under RD_LEVEL_EN.
module fifo_rd_stream #(
  parameter int DATASIZE  = 8,
  parameter int ADDRSIZE  = 4,
  parameter int AE_THRESH = 1
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rempty,
  input  logic [DATASIZE-1:0] rdata,
  output logic                rinc,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DATASIZE-1:0] m_data
`ifdef RD_LEVEL_EN
  ,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                ralmost_empty
`endif
);

  localparam int DEPTH = 3;

  logic [DATASIZE-1:0] buf_reg [DEPTH];
  logic [1:0]          head_reg;
  logic [1:0]          tail_reg;
  logic [1:0]          cnt_reg;
  logic [1:0]          cnt_next;
  logic                pend_reg;
  logic                accept;
  logic [2:0]          credit_used;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit counts buffered words plus the one still in flight from memory,
  // so rinc never depends on m_ready.
  assign credit_used = {1'b0, cnt_reg} + {2'b00, pend_reg};
  assign rinc        = rrst_n & ~rempty & (credit_used <= 3'd2);
  assign accept      = m_valid & m_ready;
  assign m_valid     = (cnt_reg != 2'd0);
  assign m_data      = buf_reg[head_reg];

  always_comb begin
    cnt_next = cnt_reg;
    case ({pend_reg, accept})
      2'b10:   cnt_next = cnt_reg + 2'd1;
      2'b01:   cnt_next = cnt_reg - 2'd1;
      default: cnt_next = cnt_reg;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      pend_reg <= 1'b0;
      head_reg <= 2'd0;
      tail_reg <= 2'd0;
      cnt_reg  <= 2'd0;
    end else begin
      pend_reg <= rinc;
      cnt_reg  <= cnt_next;
      if (pend_reg) tail_reg <= ptr_inc(tail_reg);
      if (accept)   head_reg <= ptr_inc(head_reg);
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_buf
    localparam logic [1:0] IDX = 2'(gi);
    always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n)                          buf_reg[gi] <= '0;
      else if (pend_reg && tail_reg == IDX) buf_reg[gi] <= rdata;
    end
  end

  capture_into_full : assert property (@(posedge rclk) disable iff (!rrst_n)
    !(pend_reg && cnt_reg == 2'd3));

`ifdef RD_LEVEL_EN
  localparam logic [ADDRSIZE:0] AE_LIM = AE_THRESH[ADDRSIZE:0];

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] level_next;
  logic [ADDRSIZE:0] rlevel_reg;
  logic              ae_reg;

  for (genvar gi = 0; gi <= ADDRSIZE; gi++) begin : g_g2b
    assign wbin[gi] = ^rq2_wptr[ADDRSIZE:gi];
    assign rbin[gi] = ^rptr[ADDRSIZE:gi];
  end

  // Modular subtraction handles pointer wrap; words already buffered are not counted.
  assign level_next = wbin - rbin;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rlevel_reg <= '0;
      ae_reg     <= 1'b1;
    end else begin
      rlevel_reg <= level_next;
      ae_reg     <= (level_next <= AE_LIM);
    end
  end

  assign rlevel        = rlevel_reg;
  assign ralmost_empty = ae_reg;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: vector table, hand sequences and random traffic
// checked against a queue-based model of the FIFO source and outstanding words.
module tb_fifo_rd_stream;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          rclk = 1'b0;
  logic          rrst_n;
  logic          rempty;
  logic [DW-1:0] rdata;
  logic          rinc;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
`ifdef RD_LEVEL_EN
  logic [AW:0]   rq2_wptr;
  logic [AW:0]   rptr;
  logic [AW:0]   rlevel;
  logic          ralmost_empty;
`endif

  always #5 rclk = ~rclk;

  fifo_rd_stream #(.DATASIZE(DW), .ADDRSIZE(AW), .AE_THRESH(1)) dut (
    .rclk          (rclk),
    .rrst_n        (rrst_n),
    .rempty        (rempty),
    .rdata         (rdata),
    .rinc          (rinc),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data)
`ifdef RD_LEVEL_EN
    ,
    .rq2_wptr      (rq2_wptr),
    .rptr          (rptr),
    .rlevel        (rlevel),
    .ralmost_empty (ralmost_empty)
`endif
  );

  typedef struct {
    logic          mr;
    logic          rinc;
    logic          valid;
    logic [DW-1:0] data;
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] src_q[$];   // words sitting in the FIFO memory
  logic [DW-1:0] exp_q[$];   // words popped but not yet accepted downstream
  logic          prev_rinc;
  logic          prev_hold;
  logic [DW-1:0] prev_data;
  int            delivered;
  logic          s_rinc;
  logic          s_valid;
  logic [DW-1:0] s_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // One rclk cycle: drive inputs at negedge, sample 1 time unit later, model the memory.
  task automatic step(input logic mr, input logic fe);
    logic [DW-1:0] word;
    logic          exp_rinc;
    logic          popped;
    int            in_buf;
    word    = '0;
    popped  = 1'b0;
    m_ready = mr;
    rempty  = (src_q.size() == 0) || fe;
    #1;
    s_rinc  = rinc;
    s_valid = m_valid;
    s_data  = m_data;
    in_buf  = exp_q.size() - int'(prev_rinc);
    exp_rinc = !rempty && (exp_q.size() <= 2);
    chk("rinc", 32'(s_rinc), 32'(exp_rinc));
    chk("m_valid", 32'(s_valid), 32'(in_buf > 0));
    if (in_buf > 0) chk("m_data", 32'(s_data), 32'(exp_q[0]));
    if (prev_hold) chk("hold_data", 32'(s_data), 32'(prev_data));
    prev_hold = s_valid && !mr;
    prev_data = s_data;
    if (s_valid && mr && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      delivered++;
    end
    if (s_rinc && !rempty && src_q.size() > 0) begin
      word   = src_q.pop_front();
      popped = 1'b1;
      exp_q.push_back(word);
    end
    chk("credit", 32'(exp_q.size() <= 3), 32'd1);
    prev_rinc = popped;
    @(posedge rclk);
    #1;
    rdata = popped ? word : DW'($urandom);
    @(negedge rclk);
  endtask

  // Called at a negedge; reset takes effect asynchronously.
  task automatic do_reset();
    rrst_n = 1'b0;
    rempty = (src_q.size() == 0);
    #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_rinc", 32'(rinc), 32'd0);
`ifdef RD_LEVEL_EN
    chk("rst_rlevel", 32'(rlevel), 32'd0);
    chk("rst_ae", 32'(ralmost_empty), 32'd1);
`endif
    exp_q.delete();
    prev_rinc = 1'b0;
    prev_hold = 1'b0;
    repeat (2) @(negedge rclk);
    chk("rst_rinc_hold", 32'(rinc), 32'(0));
    rrst_n = 1'b1;
  endtask

`ifdef RD_LEVEL_EN
  function automatic logic [AW:0] gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic lvl_chk(input logic [AW:0] wb, input logic [AW:0] rb);
    logic [AW:0] lv;
    rq2_wptr = gray(wb);
    rptr     = gray(rb);
    lv       = wb - rb;
    @(posedge rclk);
    #1;
    chk("rlevel", 32'(rlevel), 32'(lv));
    chk("ralmost_empty", 32'(ralmost_empty), 32'(lv <= 1));
    @(negedge rclk);
  endtask
`endif

  initial begin
    vec_t tbl[12];
    int   pulses;
    int   pushed;
    logic found;

    rrst_n = 1'b0;
    m_ready = 1'b0;
    rempty = 1'b1;
    rdata = '0;
    prev_rinc = 1'b0;
    prev_hold = 1'b0;
    prev_data = '0;
    delivered = 0;
`ifdef RD_LEVEL_EN
    rq2_wptr = '0;
    rptr = '0;
`endif
    @(negedge rclk);

    // Reset with data available, then stream 8 words
    for (int i = 1; i <= 8; i++) src_q.push_back(DW'(i));
    do_reset();
    for (int c = 0; c < 10; c++) begin
      step(1'b1, 1'b0);
      if (c == 0) chk("rinc_after_release", 32'(s_rinc), 32'd1);
      chk("stream_valid", 32'(s_valid), 32'(c >= 2));
      if (c >= 2) chk("stream_data", 32'(s_data), 32'(c - 1));
    end
    repeat (3) step(1'b1, 1'b0);

    // Backpressure vector table: 5 words, m_ready low for 6 cycles then high
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 8'h01};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 8'h01};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 8'h01};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 8'h01};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 8'h01};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 8'h02};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 8'h03};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 8'h04};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 8'h05};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 8'h00};
    for (int i = 1; i <= 5; i++) src_q.push_back(DW'(i));
    do_reset();
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].mr, 1'b0);
      if (!tbl[i].mr && s_rinc) pulses++;
      chk($sformatf("bp%0d_rinc", i), 32'(s_rinc), 32'(tbl[i].rinc));
      chk($sformatf("bp%0d_valid", i), 32'(s_valid), 32'(tbl[i].valid));
      if (tbl[i].valid) chk($sformatf("bp%0d_data", i), 32'(s_data), 32'(tbl[i].data));
    end
    chk("bp_rinc_pulses", 32'(pulses), 32'd3);

    // Near-empty: rempty toggles every cycle
    for (int i = 0; i < 10; i++) src_q.push_back(DW'(8'h40 + i));
    do_reset();
    delivered = 0;
    for (int c = 0; c < 40; c++) step(1'b1, (c % 2) == 0);
    chk("near_empty_delivered", 32'(delivered), 32'd10);

    // Mid-operation reset with cnt=2, pend=1
    for (int i = 0; i < 10; i++) src_q.push_back(DW'(8'h20 + i));
    do_reset();
    repeat (3) step(1'b0, 1'b0);
    do_reset();
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      step(1'b1, 1'b0);
      if (s_valid) begin
        found = 1'b1;
        chk("mid_reset_next_word", 32'(s_data), 32'h23);
      end
    end
    if (!found) chk("mid_reset_timeout", 32'd0, 32'd1);
    repeat (12) step(1'b1, 1'b0);

    // Random traffic
    src_q.delete();
    do_reset();
    delivered = 0;
    pushed = 0;
    for (int c = 0; c < 400; c++) begin
      if (src_q.size() < 6 && $urandom_range(0, 2) != 0) begin
        src_q.push_back(DW'($urandom));
        pushed++;
      end
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);
    end
    for (int c = 0; c < 30; c++) step(1'b1, 1'b0);
    chk("rand_delivered", 32'(delivered), 32'(pushed));
    chk("rand_outstanding", 32'(exp_q.size()), 32'd0);

`ifdef RD_LEVEL_EN
    lvl_chk(5'd5, 5'd2);
    lvl_chk(5'd5, 5'd4);
    lvl_chk(5'd1, 5'd31);
    lvl_chk(5'd7, 5'd7);
    for (int i = 0; i < 20; i++) lvl_chk(5'($urandom), 5'($urandom));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
